// File: rtl/control_pkg.sv
// Shared types for the multi-cycle sequencer: FSM state encoding, opcode
// constants and the opcode class used by DECODE.
package control_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;

  typedef enum logic [1:0] {
    CLS_R       = 2'd0,
    CLS_I       = 2'd1,
    CLS_ILLEGAL = 2'd2
  } op_class_t;

  function automatic op_class_t classify(input logic [6:0] opc);
    case (opc)
      OPC_R:   return CLS_R;
      OPC_I:   return CLS_I;
      default: return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/temporizador_imem.sv
// Fetch-wait counter: counts enabled cycles since the last clear and flags
// the cycle in which IMEM_TIMEOUT-1 wait cycles have already elapsed.
module temporizador_imem #(
  parameter int IMEM_TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CNT_W = (IMEM_TIMEOUT > 1) ? $clog2(IMEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(IMEM_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // Saturates at LAST so a stalled enable can never wrap back to zero.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt <= '0;
    end else if (en_i && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc_o = en_i && (cnt == LAST);

endmodule

// File: rtl/control_multiciclo.sv
// Multi-cycle sequencer: fetches over a req/ack handshake, classifies the
// opcode and steps the datapath enables through FETCH/DECODE/EXECUTE/WRITEBACK.
module control_multiciclo import control_pkg::*; #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter int              IMEM_TIMEOUT = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            imem_req_o,
  input  logic            imem_ack_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] ir_o,
  output logic            alu_latch_o,
  output logic            alusrc_o,
  output logic            regwrite_o,
  output logic            illegal_o,
  output logic            fault_o,
  output logic [31:0]     retired_o,
  output logic [2:0]      state_o
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  state_t          state;
  op_class_t       cls_q;
  op_class_t       dec_cls;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] ir_q;
  logic            alusrc_q;
  logic            illegal_q;
  logic            fault_q;
  logic [31:0]     retired_q;
  logic            fetch_tc;

  assign dec_cls = classify(ir_q[6:0]);

  // Counter runs only while fetching; an ack or leaving FETCH restarts it.
  temporizador_imem #(
    .IMEM_TIMEOUT (IMEM_TIMEOUT)
  ) u_temporizador (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i ((state != ST_FETCH) || imem_ack_i),
    .en_i  (state == ST_FETCH),
    .tc_o  (fetch_tc)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_RESET;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      cls_q     <= CLS_ILLEGAL;
      alusrc_q  <= 1'b0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      illegal_q <= 1'b0;
      case (state)
        ST_RESET: begin
          state <= ST_FETCH;
        end
        ST_FETCH: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (imem_ack_i) begin
            ir_q  <= imem_rdata_i;
            state <= ST_DECODE;
          end else if (fetch_tc) begin
            fault_q <= 1'b1;
            state   <= ST_FAULT;
          end
        end
        ST_DECODE: begin
          cls_q    <= dec_cls;
          alusrc_q <= (dec_cls == CLS_I);
          if (dec_cls == CLS_ILLEGAL) begin
            illegal_q <= 1'b1;
            pc_q      <= pc_q + PC_STEP;
            state     <= ST_FETCH;
          end else begin
            state <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          state <= ST_WRITEBACK;
        end
        ST_WRITEBACK: begin
          pc_q      <= pc_q + PC_STEP;
          retired_q <= retired_q + 32'd1;
          state     <= ST_FETCH;
        end
        ST_FAULT: begin
          state <= ST_FAULT;
        end
        default: begin
          fault_q <= 1'b1;
          state   <= ST_FAULT;
        end
      endcase
    end
  end

  assign imem_req_o  = (state == ST_FETCH);
  assign alu_latch_o = (state == ST_EXECUTE) && (cls_q != CLS_ILLEGAL);
  assign regwrite_o  = (state == ST_WRITEBACK) && (cls_q != CLS_ILLEGAL);
  assign alusrc_o    = alusrc_q;
  assign illegal_o   = illegal_q;
  assign fault_o     = fault_q;
  assign pc_o        = pc_q;
  assign ir_o        = ir_q;
  assign retired_o   = retired_q;
  assign state_o     = state;

endmodule
